// File: rtl/fft_consts_pkg.sv
// Shared FFT constants, complex sample type and twiddle addressing.
// Used by the twiddle sequencer, its ROM and the bench model.
package fft_consts;

    localparam int N_LOG2     = 4;
    localparam int N          = 1 << N_LOG2;
    localparam int DW         = 16;
    localparam int DW_COMPLEX = 2 * DW;
    localparam int AW         = N_LOG2 - 1;

    typedef struct packed {
        logic signed [DW-1:0] i;
        logic signed [DW-1:0] r;
    } complex_t;

    typedef logic [AW-1:0] tw_addr_t;

    typedef enum logic [1:0] {
        TW_IDLE,
        TW_RUN,
        TW_DONE
    } tw_state_e;

    // Stage s uses 2^s distinct twiddles, spaced N/2^(s+1) apart in the ROM.
    function automatic tw_addr_t tw_addr(input int s, input int b);
        int j;
        j = b & ((1 << s) - 1);
        return tw_addr_t'(j << (AW - s));
    endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Synchronous twiddle ROM, W_N^k = cos(2pi k/N) - j sin(2pi k/N), k < N/2.
// Q1.15 entries, symmetric saturation at +/-32767.
module twiddle_rom
    import fft_consts::*;
(
    input  logic     clk,
    input  tw_addr_t addr,
    output complex_t data_out
);

    localparam logic [DW_COMPLEX-1:0] LUT [0:N/2-1] = '{
        32'h0000_7FFF,
        32'hCF04_7642,
        32'hA57E_5A82,
        32'h89BE_30FC,
        32'h8001_0000,
        32'h89BE_CF04,
        32'hA57E_A57E,
        32'hCF04_89BE
    };

    always_ff @(posedge clk) begin
        data_out <= complex_t'(LUT[addr]);
    end

endmodule

// File: rtl/twiddle_addr_gen.sv
// Walks every radix-2 DIT stage and streams one twiddle per butterfly.
// ROM is addressed from next-state counters so its data lines up with them.
module twiddle_addr_gen
    import fft_consts::*;
#(
    parameter int N_STAGES = N_LOG2,
    parameter int STAGE_W  = (N_LOG2 > 1) ? $clog2(N_LOG2) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               tw_valid,
    input  logic               tw_ready,
    output complex_t           tw_data,
    output logic [STAGE_W-1:0] tw_stage,
    output logic [AW-1:0]      tw_bfly,
    output logic               tw_last
);

    localparam logic [STAGE_W-1:0] S_LAST = STAGE_W'(N_STAGES - 1);
    localparam tw_addr_t           B_LAST = tw_addr_t'(N / 2 - 1);

    tw_state_e          state;
    logic [STAGE_W-1:0] s_d;
    tw_addr_t           b_d;
    tw_addr_t           rom_addr;
    logic               fire;
    logic               stage_end;
    logic               run_end;

    assign fire      = tw_valid & tw_ready;
    assign stage_end = (tw_bfly == B_LAST);
    assign run_end   = stage_end & (tw_stage == S_LAST);

    always_comb begin
        s_d = tw_stage;
        b_d = tw_bfly;
        if (state == TW_IDLE && start) begin
            s_d = '0;
            b_d = '0;
        end else if (fire) begin
            if (run_end) begin
                s_d = '0;
                b_d = '0;
            end else if (stage_end) begin
                s_d = tw_stage + STAGE_W'(1);
                b_d = '0;
            end else begin
                b_d = tw_bfly + tw_addr_t'(1);
            end
        end
    end

    // A stall holds (s,b), so the ROM keeps re-reading the same word.
    assign rom_addr = tw_addr(int'(s_d), int'(b_d));

    twiddle_rom u_rom (
        .clk      (clk),
        .addr     (rom_addr),
        .data_out (tw_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= TW_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            tw_valid <= 1'b0;
            tw_stage <= '0;
            tw_bfly  <= '0;
            tw_last  <= 1'b0;
        end else begin
            tw_stage <= s_d;
            tw_bfly  <= b_d;
            tw_last  <= (b_d == B_LAST);
            unique case (state)
                TW_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= TW_RUN;
                        busy     <= 1'b1;
                        tw_valid <= 1'b1;
                    end
                end
                TW_RUN: begin
                    if (fire && run_end) begin
                        state    <= TW_DONE;
                        busy     <= 1'b0;
                        tw_valid <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                TW_DONE: begin
                    state <= TW_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state    <= TW_IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    tw_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_twiddle_addr_gen.sv
// Bench for twiddle_addr_gen: full-depth and two-stage builds against
// a trig-based reference of the stage/butterfly twiddle sequence.
module tb_twiddle_addr_gen;
    import fft_consts::*;

    localparam int SW   = (N_LOG2 > 1) ? $clog2(N_LOG2) : 1;
    localparam int HALF = N / 2;
    localparam real PI  = 3.14159265358979323846;

    logic clk;
    logic rst_n;
    logic start;
    logic sel;
    logic tw_ready;

    logic start1, start2;
    logic busy1, done1, valid1, last1;
    logic busy2, done2, valid2, last2;
    complex_t data1, data2;
    logic [SW-1:0] stage1, stage2;
    logic [AW-1:0] bfly1, bfly2;

    logic o_busy, o_done, o_valid, o_last;
    logic [DW_COMPLEX-1:0] o_data;
    logic [SW-1:0] o_stage;
    logic [AW-1:0] o_bfly;

    int tests;
    int fails;

    assign start1  = start & ~sel;
    assign start2  = start & sel;
    assign o_busy  = sel ? busy2 : busy1;
    assign o_done  = sel ? done2 : done1;
    assign o_valid = sel ? valid2 : valid1;
    assign o_last  = sel ? last2 : last1;
    assign o_data  = sel ? data2 : data1;
    assign o_stage = sel ? stage2 : stage1;
    assign o_bfly  = sel ? bfly2 : bfly1;

    twiddle_addr_gen u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start1),
        .busy     (busy1),
        .done     (done1),
        .tw_valid (valid1),
        .tw_ready (tw_ready),
        .tw_data  (data1),
        .tw_stage (stage1),
        .tw_bfly  (bfly1),
        .tw_last  (last1)
    );

    twiddle_addr_gen #(.N_STAGES(2)) u_dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start2),
        .busy     (busy2),
        .done     (done2),
        .tw_valid (valid2),
        .tw_ready (tw_ready),
        .tw_data  (data2),
        .tw_stage (stage2),
        .tw_bfly  (bfly2),
        .tw_last  (last2)
    );

    always #5 clk = ~clk;

    function automatic int rnd(input real x);
        return $rtoi($floor(x + 0.5));
    endfunction

    function automatic int sat(input int x);
        int lim;
        lim = (1 << (DW - 1)) - 1;
        if (x > lim) return lim;
        if (x < -lim) return -lim;
        return x;
    endfunction

    // W_N^k in Q1.15, imag part = -sin.
    function automatic logic [DW_COMPLEX-1:0] ref_tw(input int k);
        real full, ang;
        int re, im;
        full = 2.0 ** (DW - 1);
        ang  = 2.0 * PI * real'(k) / real'(N);
        re   = sat(rnd(full * $cos(ang)));
        im   = sat(rnd(-full * $sin(ang)));
        return {DW'(im), DW'(re)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic kick;
        start    = 1'b1;
        tw_ready = 1'($urandom_range(1));
        step;
        start = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 64'(o_valid), 64'(0));
        chk({tag, "_busy"}, 64'(o_busy), 64'(0));
        chk({tag, "_done"}, 64'(o_done), 64'(0));
    endtask

    // Called one sample after the accepted start edge.
    task automatic run(input int pct, input int ns, input int mid_at,
                       input bit done_start, input int abort_at);
        int total, beat, s, b, k;
        bit fin, rdy;
        total = ns * HALF;
        beat  = 0;
        fin   = 1'b0;
        for (int cyc = 0; cyc < total * 10 + 20 && !fin; cyc++) begin
            if (beat < total) begin
                s = beat / HALF;
                b = beat % HALF;
                k = (b % (1 << s)) * (HALF >> s);
                chk("valid", 64'(o_valid), 64'(1));
                chk("busy", 64'(o_busy), 64'(1));
                chk("done_early", 64'(o_done), 64'(0));
                chk("stage", 64'(o_stage), 64'(s));
                chk("bfly", 64'(o_bfly), 64'(b));
                chk("last", 64'(o_last), 64'(b == HALF - 1));
                chk("data", 64'(o_data), 64'(ref_tw(k)));
                if (beat == abort_at) begin
                    rst_n    = 1'b0;
                    tw_ready = 1'b1;
                    step;
                    rst_n = 1'b1;
                    chk_idle("abort");
                    chk("abort_stage", 64'(o_stage), 64'(0));
                    chk("abort_bfly", 64'(o_bfly), 64'(0));
                    repeat (3) begin
                        step;
                        chk_idle("post_abort");
                    end
                    fin = 1'b1;
                end else begin
                    rdy      = ($urandom_range(99) < pct);
                    tw_ready = rdy;
                    start    = (beat == mid_at);
                    if (rdy && o_valid) beat++;
                    step;
                    start = 1'b0;
                end
            end else begin
                chk("end_valid", 64'(o_valid), 64'(0));
                chk("end_busy", 64'(o_busy), 64'(0));
                chk("done_pulse", 64'(o_done), 64'(1));
                tw_ready = 1'($urandom_range(1));
                start    = done_start;
                step;
                start = 1'b0;
                chk_idle("after_done");
                fin = 1'b1;
            end
        end
        chk("run_complete", 64'(fin), 64'(1));
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        clk      = 1'b0;
        sel      = 1'b0;
        rst_n    = 1'b0;
        start    = 1'b1;
        tw_ready = 1'b0;

        repeat (3) begin
            step;
            chk("rst_valid", 64'(valid1), 64'(0));
            chk("rst_busy", 64'(busy1), 64'(0));
            chk("rst_done", 64'(done1), 64'(0));
            chk("rst_stage", 64'(stage1), 64'(0));
            chk("rst_bfly", 64'(bfly1), 64'(0));
            chk("rst_last", 64'(last1), 64'(0));
            chk("rst2_valid", 64'(valid2), 64'(0));
            chk("rst2_done", 64'(done2), 64'(0));
        end
        start = 1'b0;
        rst_n = 1'b1;
        step;
        chk_idle("idle");

        kick;
        run(100, N_LOG2, -1, 1'b0, -1);

        kick;
        run(50, N_LOG2, -1, 1'b0, -1);

        kick;
        run(70, N_LOG2, 10, 1'b1, -1);
        kick;
        run(100, N_LOG2, -1, 1'b0, -1);

        kick;
        run(60, N_LOG2, -1, 1'b0, 2 * HALF + 3);
        kick;
        run(100, N_LOG2, -1, 1'b0, -1);

        sel = 1'b1;
        step;
        chk_idle("idle2");
        kick;
        run(100, 2, -1, 1'b0, -1);
        kick;
        run(50, 2, -1, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
